// File: rtl/dfs_controller.sv
// dfs_controller: control FSM for a depth-first search datapath (child push, leaf best-path update, pop, result streaming).
// Latency: controls are registered and valid during the cycle their state is occupied; conditional controls use flags seen on the entering edge.
// Backpressure: none on the search; while stop is low OUT keeps streaming results, stop high moves to FIN. Option: `DFS_TIE_REPLACE_EN.
module dfs_controller #(
  parameter int C = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       DONE,
  input  logic       kone,
  input  logic       SNumel,
  input  logic       nc0,
  input  logic       nc1,
  input  logic       nc2,
  input  logic       nc3,
  input  logic       nc4,
  input  logic       wl,
  input  logic       wg,
  output logic       LD_path,
  output logic       LD_pm,
  output logic       LD_adrs,
  output logic       a1,
  output logic       LD_SA,
  output logic       sa3,
  output logic       sa1,
  output logic       LD_ix,
  output logic       SI1,
  output logic       SI2,
  output logic       LD_SI,
  output logic       LD_nk,
  output logic       LD_k,
  output logic       LD_SN,
  output logic       sn1,
  output logic       LD_nc,
  output logic       LD_wpm,
  output logic       wpm1,
  output logic       LD_wp,
  output logic       wp1,
  output logic       wp2,
  output logic       LD_w,
  output logic       LD_WK1,
  output logic       LD_mn,
  output logic       mn1,
  output logic       done,
  output logic [1:0] nk1,
  output logic [1:0] sn2,
  output logic [3:0] sa2,
  output logic       busy,
  output logic       finished
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LDK, S_RDW, S_RDNC, S_PUSH, S_SETN,
    S_LEAF, S_POP, S_NEXT, S_OUTI, S_OUT, S_FIN
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       finished;
    logic       done;
    logic       ld_path;
    logic       ld_pm;
    logic       ld_adrs;
    logic       a1;
    logic       ld_sa;
    logic       sa3;
    logic       sa1;
    logic [3:0] sa2;
    logic       ld_ix;
    logic       ld_si;
    logic       si1;
    logic       si2;
    logic       ld_nk;
    logic [1:0] nk1;
    logic       ld_k;
    logic       ld_sn;
    logic [1:0] sn2;
    logic       sn1;
    logic       ld_nc;
    logic       ld_wpm;
    logic       wpm1;
    logic       ld_wp;
    logic       wp1;
    logic       wp2;
    logic       ld_w;
    logic       ld_wk1;
    logic       ld_mn;
    logic       mn1;
  } ctl_t;

  // Last child slot index; PUSH never goes past it whatever the flags say.
  localparam logic [3:0] JLAST = 4'(C - 1);

  state_t     state_q, state_d;
  logic [3:0] j_q, j_d;
  ctl_t       ctl_q, ctl_d;

  logic [4:0] nc_vec;
  logic       more_child;
  logic       pm_update;

  assign nc_vec = {nc4, nc3, nc2, nc1, nc0};

  // Equal weights either keep the first path found or let the latest one win.
`ifdef DFS_TIE_REPLACE_EN
  assign pm_update = wl | ~wg;
`else
  assign pm_update = wl;
`endif

  // Another slot follows slot j when the node reports at least j+2 children and slots remain.
  always_comb begin
    more_child = 1'b0;
    if ((j_q < JLAST) && (j_q < 4'd3)) begin
      more_child = nc_vec[3'(j_q) + 3'd2];
    end
  end

  // Next-state and child-slot counter.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: state_d = S_LDK;
      S_LDK:  state_d = S_RDW;
      S_RDW:  state_d = S_RDNC;
      // A node without a first-child flag is treated as a leaf too, so no empty slot is ever pushed.
      S_RDNC: state_d = (nc0 || !nc1) ? S_LEAF : S_PUSH;
      S_PUSH: begin
        if (more_child) j_d = j_q + 4'd1;
        else            state_d = S_SETN;
      end
      S_SETN: begin
        state_d = S_LDK;
        j_d     = '0;
      end
      S_LEAF: state_d = S_POP;
      S_POP:  state_d = S_NEXT;
      S_NEXT: begin
        if (DONE)        state_d = S_OUTI;
        else if (SNumel) state_d = S_POP;
        else             state_d = S_RDW;
      end
      S_OUTI: state_d = S_OUT;
      S_OUT:  if (stop) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controls for the state being entered, so they are registered alongside the state.
  always_comb begin
    ctl_d      = '0;
    ctl_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_INIT: begin
        ctl_d.ld_sa  = 1'b1;
        ctl_d.ld_si  = 1'b1;
        ctl_d.ld_sn  = 1'b1;
        ctl_d.ld_wpm = 1'b1;
        ctl_d.ld_nk  = 1'b1;
      end
      S_LDK: begin
        ctl_d.ld_k  = 1'b1;
        ctl_d.ld_ix = 1'b1;
      end
      S_RDW: begin
        ctl_d.ld_w    = 1'b1;
        ctl_d.ld_adrs = 1'b1;
        ctl_d.ld_path = 1'b1;
        if (kone) ctl_d.ld_wp  = 1'b1;
        else      ctl_d.ld_wk1 = 1'b1;
      end
      S_RDNC: begin
        ctl_d.ld_nc   = 1'b1;
        ctl_d.ld_adrs = 1'b1;
        if (!kone) begin
          ctl_d.ld_wp = 1'b1;
          ctl_d.wp2   = 1'b1;
        end
      end
      S_PUSH: begin
        ctl_d.ld_sa   = 1'b1;
        ctl_d.sa3     = 1'b1;
        ctl_d.sa1     = 1'b1;
        ctl_d.sa2     = j_d;
        ctl_d.ld_adrs = 1'b1;
      end
      S_SETN: begin
        ctl_d.ld_sn = 1'b1;
        ctl_d.sn2   = 2'd2;
        ctl_d.sn1   = 1'b1;
        ctl_d.ld_si = 1'b1;
        ctl_d.si1   = 1'b1;
        ctl_d.ld_nk = 1'b1;
        ctl_d.nk1   = 2'd1;
      end
      S_LEAF: begin
        if (pm_update) begin
          ctl_d.ld_wpm = 1'b1;
          ctl_d.wpm1   = 1'b1;
          ctl_d.ld_pm  = 1'b1;
        end
      end
      S_POP: begin
        ctl_d.ld_sn = 1'b1;
        ctl_d.sn2   = 2'd1;
        ctl_d.ld_si = 1'b1;
        ctl_d.si2   = 1'b1;
      end
      S_NEXT: begin
        if (DONE) begin
          ctl_d.busy = 1'b1;
        end else if (SNumel) begin
          ctl_d.ld_nk = 1'b1;
          ctl_d.nk1   = 2'd2;
          ctl_d.ld_k  = 1'b1;
        end else begin
          ctl_d.ld_ix   = 1'b1;
          ctl_d.ld_adrs = 1'b1;
          ctl_d.a1      = 1'b1;
        end
      end
      S_OUTI: ctl_d.ld_mn = 1'b1;
      S_OUT: begin
        ctl_d.done = 1'b1;
        if (!stop) begin
          ctl_d.ld_mn = 1'b1;
          ctl_d.mn1   = 1'b1;
        end
      end
      S_FIN: ctl_d.finished = 1'b1;
      default: ctl_d.busy = 1'b0;
    endcase
  end

  // State, slot counter and registered controls; reset forces IDLE with all controls low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      ctl_q   <= ctl_d;
    end
  end

  assign busy     = ctl_q.busy;
  assign finished = ctl_q.finished;
  assign done     = ctl_q.done;
  assign LD_path  = ctl_q.ld_path;
  assign LD_pm    = ctl_q.ld_pm;
  assign LD_adrs  = ctl_q.ld_adrs;
  assign a1       = ctl_q.a1;
  assign LD_SA    = ctl_q.ld_sa;
  assign sa3      = ctl_q.sa3;
  assign sa1      = ctl_q.sa1;
  assign sa2      = ctl_q.sa2;
  assign LD_ix    = ctl_q.ld_ix;
  assign LD_SI    = ctl_q.ld_si;
  assign SI1      = ctl_q.si1;
  assign SI2      = ctl_q.si2;
  assign LD_nk    = ctl_q.ld_nk;
  assign nk1      = ctl_q.nk1;
  assign LD_k     = ctl_q.ld_k;
  assign LD_SN    = ctl_q.ld_sn;
  assign sn2      = ctl_q.sn2;
  assign sn1      = ctl_q.sn1;
  assign LD_nc    = ctl_q.ld_nc;
  assign LD_wpm   = ctl_q.ld_wpm;
  assign wpm1     = ctl_q.wpm1;
  assign LD_wp    = ctl_q.ld_wp;
  assign wp1      = ctl_q.wp1;
  assign wp2      = ctl_q.wp2;
  assign LD_w     = ctl_q.ld_w;
  assign LD_WK1   = ctl_q.ld_wk1;
  assign LD_mn    = ctl_q.ld_mn;
  assign mn1      = ctl_q.mn1;

endmodule

// File: tb/tb_dfs_controller.sv
// tb_dfs_controller: random depth-first walks driven into dfs_controller, expected controls queued per cycle.
// Latency: each driven cycle queues the control word expected after the next rising edge.
// Backpressure: stop is driven by the bench to hold or release result streaming.
module tb_dfs_controller;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, DONE, kone, SNumel, nc0, nc1, nc2, nc3, nc4, wl, wg;
  logic LD_path, LD_pm, LD_adrs, a1, LD_SA, sa3, sa1, LD_ix, SI1, SI2, LD_SI, LD_nk, LD_k;
  logic LD_SN, sn1, LD_nc, LD_wpm, wpm1, LD_wp, wp1, wp2, LD_w, LD_WK1, LD_mn, mn1, done;
  logic [1:0] nk1, sn2;
  logic [3:0] sa2;
  logic busy, finished;

  dfs_controller #(.C(C)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .DONE(DONE), .kone(kone), .SNumel(SNumel),
    .nc0(nc0), .nc1(nc1), .nc2(nc2), .nc3(nc3), .nc4(nc4), .wl(wl), .wg(wg),
    .LD_path(LD_path), .LD_pm(LD_pm), .LD_adrs(LD_adrs), .a1(a1), .LD_SA(LD_SA), .sa3(sa3),
    .sa1(sa1), .LD_ix(LD_ix), .SI1(SI1), .SI2(SI2), .LD_SI(LD_SI), .LD_nk(LD_nk), .LD_k(LD_k),
    .LD_SN(LD_SN), .sn1(sn1), .LD_nc(LD_nc), .LD_wpm(LD_wpm), .wpm1(wpm1), .LD_wp(LD_wp),
    .wp1(wp1), .wp2(wp2), .LD_w(LD_w), .LD_WK1(LD_WK1), .LD_mn(LD_mn), .mn1(mn1), .done(done),
    .nk1(nk1), .sn2(sn2), .sa2(sa2), .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, finished, done;
    logic LD_path, LD_pm, LD_adrs, a1;
    logic LD_SA, sa3, sa1;
    logic [3:0] sa2;
    logic LD_ix, LD_SI, SI1, SI2;
    logic LD_nk;
    logic [1:0] nk1;
    logic LD_k, LD_SN;
    logic [1:0] sn2;
    logic sn1;
    logic LD_nc, LD_wpm, wpm1, LD_wp, wp1, wp2, LD_w, LD_WK1, LD_mn, mn1;
  } obs_t;

  localparam int P_IDLE = 0, P_INIT = 1, P_LDK = 2, P_RDW = 3, P_RDNC = 4, P_PUSH = 5, P_SETN = 6;
  localparam int P_LEAF = 7, P_POP = 8, P_NEXT = 9, P_OUTI = 10, P_OUT = 11, P_FIN = 12;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic obs_t actual();
    obs_t a;
    a = '{busy, finished, done, LD_path, LD_pm, LD_adrs, a1, LD_SA, sa3, sa1, sa2,
          LD_ix, LD_SI, SI1, SI2, LD_nk, nk1, LD_k, LD_SN, sn2, sn1,
          LD_nc, LD_wpm, wpm1, LD_wp, wp1, wp2, LD_w, LD_WK1, LD_mn, mn1};
    return a;
  endfunction

  // Control word the specification table lists for a phase; arg carries the phase's condition.
  function automatic obs_t expect_of(input int p, input int arg);
    obs_t e;
    e = '0;
    e.busy = (p != P_IDLE);
    case (p)
      P_INIT: begin e.LD_SA = 1; e.LD_SI = 1; e.LD_SN = 1; e.LD_wpm = 1; e.LD_nk = 1; end
      P_LDK:  begin e.LD_k = 1; e.LD_ix = 1; end
      P_RDW:  begin
        e.LD_w = 1; e.LD_adrs = 1; e.LD_path = 1;
        if (arg != 0) e.LD_wp = 1; else e.LD_WK1 = 1;
      end
      P_RDNC: begin
        e.LD_nc = 1; e.LD_adrs = 1;
        if (arg == 0) begin e.LD_wp = 1; e.wp2 = 1; end
      end
      P_PUSH: begin e.LD_SA = 1; e.sa3 = 1; e.sa1 = 1; e.sa2 = 4'(arg); e.LD_adrs = 1; end
      P_SETN: begin
        e.LD_SN = 1; e.sn2 = 2'd2; e.sn1 = 1; e.LD_SI = 1; e.SI1 = 1; e.LD_nk = 1; e.nk1 = 2'd1;
      end
      P_LEAF: if (arg != 0) begin e.LD_wpm = 1; e.wpm1 = 1; e.LD_pm = 1; end
      P_POP:  begin e.LD_SN = 1; e.sn2 = 2'd1; e.LD_SI = 1; e.SI2 = 1; end
      P_NEXT: begin
        if (arg == 1) begin e.LD_nk = 1; e.nk1 = 2'd2; e.LD_k = 1; end
        else if (arg == 2) begin e.LD_ix = 1; e.LD_adrs = 1; e.a1 = 1; end
      end
      P_OUTI: e.LD_mn = 1;
      P_OUT:  begin e.done = 1; if (arg != 0) begin e.LD_mn = 1; e.mn1 = 1; end end
      P_FIN:  e.finished = 1;
      default: e.busy = 0;
    endcase
    return e;
  endfunction

  // Best-path update rule at a leaf: wl wins (even with wg), wg keeps, equal weight per build option.
  function automatic int leaf_update(input int w);
    if (w[0]) return 1;
    if (w[1]) return 0;
`ifdef DFS_TIE_REPLACE_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string t, input obs_t a, input obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", t, a, e);
    end
  endtask

  // Called at a falling edge with inputs already set: queue expectation, let one rising edge pass.
  task automatic step(input string t, input int p, input int arg);
    exp_q.push_back(expect_of(p, arg));
    tag_q.push_back(t);
    @(negedge clk);
  endtask

  task automatic noise();
    start = ($urandom_range(0, 3) == 0);
    stop  = $urandom_range(0, 1);
  endtask

  task automatic set_nc(input int n);
    nc0 = (n == 0); nc1 = (n >= 1); nc2 = (n >= 2); nc3 = (n >= 3); nc4 = (n >= 4);
  endtask

  // One search: random tree walk from the root, then result streaming of out_n cycles.
  task automatic run_search(input int root_n, input int root_w, input int budget,
                            input int out_n, input bit out_imm);
    int where, visited, pops, n, kn, w, slots, nx;
    bit fin;
    start = 1; step("start", P_INIT, 0);
    noise(); step("init", P_LDK, 0);
    where = 0; visited = 0; pops = 0; kn = 0; fin = 0;
    while (!fin) begin
      if (where == 0) begin
        kn = $urandom_range(0, 1); kone = kn[0];
        noise(); step("ldk", P_RDW, kn); where = 1;
      end else if (where == 1) begin
        noise(); step("rdw", P_RDNC, kn);
        n = (visited == 0 && root_n >= 0) ? root_n : $urandom_range(0, 5);
        if (visited >= budget) n = 0;
        w = (visited == 0 && root_w >= 0) ? root_w : $urandom_range(0, 3);
        visited++;
        noise(); set_nc(n); wl = w[0]; wg = w[1];
        if (n == 0) begin
          step("rdnc_leaf", P_LEAF, leaf_update(w));
          noise(); step("leaf", P_POP, 0); where = 2;
        end else begin
          slots = (n > C) ? C : n;
          step("rdnc_push", P_PUSH, 0);
          for (int s = 0; s < slots; s++) begin
            noise();
            if (s < slots - 1) step("push", P_PUSH, s + 1);
            else               step("push_setn", P_SETN, 0);
          end
          noise(); step("setn", P_LDK, 0); where = 0;
        end
      end else begin
        pops++;
        nx = $urandom_range(0, 2);
        if (visited >= budget || pops >= 4 * budget) nx = 0;
        noise();
        DONE = (nx == 0);
        SNumel = (nx == 1) || (nx == 0 && $urandom_range(0, 1) == 1);
        step("pop", P_NEXT, nx);
        if (nx == 0) begin
          noise(); step("next_outi", P_OUTI, 0); fin = 1;
        end else if (nx == 1) begin
          noise(); step("next_pop", P_POP, 0);
        end else begin
          kn = $urandom_range(0, 1); kone = kn[0];
          noise(); step("next_rdw", P_RDW, kn); where = 1;
        end
      end
    end
    DONE = 0; SNumel = 0;
    if (out_imm) begin
      noise(); stop = 1; step("outi_stop", P_OUT, 0);
    end else begin
      for (int i = 0; i < out_n; i++) begin
        noise(); stop = 0; step("out_stream", P_OUT, 1);
      end
    end
    noise(); stop = 1; step("out_fin", P_FIN, 0);
    noise(); start = 0; step("fin", P_IDLE, 0);
    start = 0; step("idle", P_IDLE, 0);
  endtask

  // Reset while the third child slot is being pushed.
  task automatic reset_mid_push();
    start = 1; step("rp_start", P_INIT, 0);
    start = 0; step("rp_init", P_LDK, 0);
    kone = 0; step("rp_ldk", P_RDW, 0);
    step("rp_rdw", P_RDNC, 0);
    set_nc(4); step("rp_push0", P_PUSH, 0);
    step("rp_push1", P_PUSH, 1);
    step("rp_push2", P_PUSH, 2);
    #1 rst = 1; start = 1;
    #1 check("rst_mid_push_async", actual(), '0);
    @(negedge clk);
    check("rst_mid_push_held", actual(), '0);
    rst = 0; start = 0;
    step("post_rst_idle0", P_IDLE, 0);
    step("post_rst_idle1", P_IDLE, 0);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation after each rising edge.
  initial begin
    forever begin
      obs_t  e;
      string t;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, actual(), e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; start = 0; stop = 0; DONE = 0; kone = 0; SNumel = 0; wl = 0; wg = 0;
    set_nc(0);
    #1 rst = 1;
    #2 check("reset_async", actual(), '0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    check("reset_hold", actual(), '0);
    rst = 0; start = 0;
    step("idle0", P_IDLE, 0);
    run_search(0, 1, 1, 3, 1'b0);
    run_search(0, 0, 1, 1, 1'b0);
    run_search(0, 3, 1, 2, 1'b0);
    run_search(3, -1, 2, 2, 1'b0);
    run_search(4, -1, 2, 1, 1'b1);
    run_search(5, -1, 2, 1, 1'b0);
    reset_mid_push();
    for (int r = 0; r < 30; r++) begin
      run_search(-1, -1, $urandom_range(1, 6), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
